// File: rtl/rej_sampler_multi.sv
// Rejection sampler: takes NUM_LANES raw samples per input beat, keeps those
// whose low VLD_W bits are below REJ_VALUE, and packs them into a shift
// buffer. The buffer is read out NUM_OUT coefficients at a time, and the block
// stops once NUM_COEFF coefficients have been collected for a polynomial.
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   zeroize         synchronous clear of all state
//   start_i         begin one polynomial (honoured in IDLE only)
//   data_valid_i / data_i / data_ready_o      raw sample beats in
//   coeff_valid_o / coeff_data_o / coeff_ready_i  coefficient beats out
//   busy_o, done_o  status; done_o pulses for one cycle at completion
module rej_sampler_multi #(
  parameter int unsigned REJ_SAMPLE_W = 24,
  parameter int unsigned REJ_VALUE    = 8380417,
  parameter int unsigned NUM_LANES    = 5,
  parameter int unsigned NUM_OUT      = 4,
  parameter int unsigned BUF_DEPTH    = 12,
  parameter int unsigned NUM_COEFF    = 256,
  localparam int unsigned VLD_W       = $clog2(REJ_VALUE)
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            zeroize,
  input  logic                            start_i,
  input  logic                            data_valid_i,
  input  logic [NUM_LANES*REJ_SAMPLE_W-1:0] data_i,
  output logic                            data_ready_o,
  output logic                            coeff_valid_o,
  output logic [NUM_OUT*VLD_W-1:0]        coeff_data_o,
  input  logic                            coeff_ready_i,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(NUM_COEFF + 1);

  // Parameter sanity checks at elaboration
  generate
    if (BUF_DEPTH < NUM_LANES + NUM_OUT) begin : g_chk_depth
      $error("BUF_DEPTH must be >= NUM_LANES + NUM_OUT");
    end
    if (NUM_COEFF % NUM_OUT != 0) begin : g_chk_coeff
      $error("NUM_COEFF must be a multiple of NUM_OUT");
    end
    if (REJ_SAMPLE_W < VLD_W) begin : g_chk_width
      $error("REJ_SAMPLE_W must be >= VLD_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [VLD_W-1:0] buf_q [BUF_DEPTH];
  logic [VLD_W-1:0] buf_d [BUF_DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_go, pop_go;

  // Upper sample bits are ignored by design
  logic data_unused;
  assign data_unused = ^data_i;

  // Outputs decoded from registered state only
  assign data_ready_o  = (state_q == RUN) && (occ_q <= OCC_W'(BUF_DEPTH - NUM_LANES));
  assign coeff_valid_o = ((state_q == RUN) || (state_q == DRAIN)) && (occ_q >= OCC_W'(NUM_OUT));
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

  // Head of the buffer is always on the output, oldest at the LSBs
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign coeff_data_o[g*VLD_W +: VLD_W] = buf_q[g];
  end

  assign push_go = data_valid_i && data_ready_o;
  assign pop_go  = coeff_valid_o && coeff_ready_i;

  // Next state: pop-shift first, then append compacted valid lanes at the tail
  always_comb begin
    int unsigned base;
    int unsigned taken;
    int unsigned room;
    logic [VLD_W-1:0] lane;

    state_d = state_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    base    = 32'(occ_q);
    taken   = 0;
    room    = NUM_COEFF - 32'(cnt_q);
    lane    = '0;

    if (pop_go) begin
      for (int unsigned i = 0; i < BUF_DEPTH - NUM_OUT; i++) begin
        buf_d[i] = buf_q[i + NUM_OUT];
      end
      for (int unsigned i = BUF_DEPTH - NUM_OUT; i < BUF_DEPTH; i++) begin
        buf_d[i] = '0;
      end
      base = 32'(occ_q) - NUM_OUT;
    end

    if (push_go) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        lane = data_i[l*REJ_SAMPLE_W +: VLD_W];
        // Lanes past the polynomial's coefficient budget are dropped
        if ((32'(lane) < REJ_VALUE) && (taken < room) && (base + taken < BUF_DEPTH)) begin
          buf_d[base + taken] = lane;
          taken = taken + 1;
        end
      end
    end

    occ_d = OCC_W'(base + taken);
    cnt_d = cnt_q + CNT_W'(taken);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN:   if (cnt_q == CNT_W'(NUM_COEFF)) state_d = DRAIN;
      DRAIN: if (occ_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (zeroize) begin
      state_d = IDLE;
      occ_d   = '0;
      cnt_d   = '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_d[i] = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      occ_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_rej_sampler_multi.sv
// Self-checking bench for rej_sampler_multi: directed steps plus a random
// polynomial, checked against a queue-based reference of the sampling rules.
module tb_rej_sampler_multi;

  localparam int unsigned LW  = 24;
  localparam int unsigned REJ = 8380417;
  localparam int unsigned NL  = 5;
  localparam int unsigned NO  = 4;
  localparam int unsigned NC  = 256;
  localparam int unsigned VW  = 23;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              zeroize;
  logic              start_i;
  logic              data_valid_i;
  logic [NL*LW-1:0]  data_i;
  logic              data_ready_o;
  logic              coeff_valid_o;
  logic [NO*VW-1:0]  coeff_data_o;
  logic              coeff_ready_i;
  logic              busy_o;
  logic              done_o;

  rej_sampler_multi dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .zeroize       (zeroize),
    .start_i       (start_i),
    .data_valid_i  (data_valid_i),
    .data_i        (data_i),
    .data_ready_o  (data_ready_o),
    .coeff_valid_o (coeff_valid_o),
    .coeff_data_o  (coeff_data_o),
    .coeff_ready_i (coeff_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_q[$];
  int unsigned got_q[$];
  logic        rnd_rdy = 1'b0;

  // Output beats and done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_b && coeff_valid_o && coeff_ready_i) begin
      for (int i = 0; i < NO; i++) got_q.push_back(32'(coeff_data_o[i*VW +: VW]));
    end
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: keep lanes whose low 23 bits are below q, up to NC per polynomial
  task automatic model_beat(input logic [NL*LW-1:0] b);
    int unsigned v;
    for (int l = 0; l < NL; l++) begin
      v = 32'(b[l*LW +: VW]);
      if (v < REJ && exp_cnt < NC) begin
        exp_q.push_back(v);
        exp_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) coeff_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [NL*LW-1:0] b);
    logic acc;
    int   n;
    n = 0;
    data_i = b;
    data_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      acc = data_ready_o;
      tick();
      if (acc) begin
        model_beat(b);
        break;
      end
      n++;
      if (n > 2000) begin
        chk("beat_timeout", 1'b1, 1'b0);
        break;
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic start_poly();
    got_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_zeroize();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    repeat (4) tick();
    chk({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    chk({tag, "_idle"}, 128'(busy_o), 128'(0));
  endtask

  // Compare the first n collected coefficients to the reference
  task automatic cmp_prefix(input string tag, input int n);
    int errs;
    errs = 0;
    chk({tag, "_count"}, 128'(got_q.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) errs++;
      else if (got_q[i] != exp_q[i]) errs++;
    end
    chk({tag, "_order"}, 128'(errs), 128'(0));
  endtask

  function automatic logic [NL*LW-1:0] beat5(input int unsigned a, b, c, d, e);
    return {24'(e), 24'(d), 24'(c), 24'(b), 24'(a)};
  endfunction

  function automatic logic [NL*LW-1:0] rand_beat(input bit all_valid);
    logic [NL*LW-1:0] r;
    logic [VW-1:0]    low;
    for (int l = 0; l < NL; l++) begin
      if (!all_valid && $urandom_range(0, 3) == 0) low = VW'($urandom_range(REJ, 8388607));
      else low = VW'($urandom_range(0, REJ - 1));
      r[l*LW +: LW] = {1'($urandom_range(0, 1)), low};
    end
    return r;
  endfunction

  initial begin
    logic [NO*VW-1:0] w;
    rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0;
    data_valid_i = 1'b0; data_i = '0; coeff_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 128'(data_ready_o), 128'(0));
    chk("rst_cvalid", 128'(coeff_valid_o), 128'(0));
    chk("rst_cdata", 128'(coeff_data_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    tick();

    // All lanes valid: 0..259 in 52 beats, full throughput
    coeff_ready_i = 1'b1;
    done_cnt = 0;
    start_poly();
    chk("start_busy", 128'(busy_o), 128'(1));
    chk("start_ready", 128'(data_ready_o), 128'(1));
    for (int k = 0; k < 52; k++) send_beat(beat5(5*k, 5*k+1, 5*k+2, 5*k+3, 5*k+4));
    wait_done("allvalid");
    cmp_prefix("allvalid", NC);
    chk("allvalid_last", 128'(got_q.size() == NC ? got_q[NC-1] : 0), 128'(255));

    // Rejection boundaries
    start_poly();
    send_beat(beat5(8380416, 8380417, 24'hFFFFFF, 24'h800001, 5));
    send_beat(beat5(10, 11, 12, 13, 14));
    repeat (4) tick();
    cmp_prefix("bound", 8);
    chk("bound_max", 128'(got_q.size() > 0 ? got_q[0] : 0), 128'(8380416));
    chk("bound_hibit", 128'(got_q.size() > 1 ? got_q[1] : 0), 128'(1));
    chk("bound_next", 128'(got_q.size() > 2 ? got_q[2] : 0), 128'(5));
    do_zeroize();

    // Backpressure: two beats fill ten slots
    coeff_ready_i = 1'b0;
    start_poly();
    send_beat(rand_beat(1'b1));
    send_beat(rand_beat(1'b1));
    chk("bp_ready_low", 128'(data_ready_o), 128'(0));
    chk("bp_cvalid", 128'(coeff_valid_o), 128'(1));
    for (int i = 0; i < NO; i++) w[i*VW +: VW] = VW'(exp_q[i]);
    chk("bp_head", 128'(coeff_data_o), 128'(w));
    coeff_ready_i = 1'b1;
    tick();
    chk("bp_resume", 128'(data_ready_o), 128'(1));
    repeat (3) tick();
    chk("bp_tail_cvalid", 128'(coeff_valid_o), 128'(0));
    cmp_prefix("bp", 8);

    // All-reject beats leave occupancy alone
    for (int k = 0; k < 3; k++) send_beat(beat5(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF));
    repeat (2) tick();
    chk("rej_cvalid", 128'(coeff_valid_o), 128'(0));
    chk("rej_count", 128'(got_q.size()), 128'(8));

    // Zeroize with seven entries held
    coeff_ready_i = 1'b0;
    send_beat(rand_beat(1'b1));
    chk("zer_pre_cvalid", 128'(coeff_valid_o), 128'(1));
    do_zeroize();
    chk("zer_busy", 128'(busy_o), 128'(0));
    chk("zer_cvalid", 128'(coeff_valid_o), 128'(0));
    chk("zer_ready", 128'(data_ready_o), 128'(0));
    chk("zer_cdata", 128'(coeff_data_o), 128'(0));
    tick();

    // Fresh random polynomial with random sink stalls
    done_cnt = 0;
    rnd_rdy = 1'b1;
    start_poly();
    while (exp_cnt < NC) send_beat(rand_beat(1'b0));
    wait_done("rand");
    cmp_prefix("rand", NC);
    rnd_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
